nixie_scan_ctrl: RTL and testbench

NIXIE_SCAN_CTRL -- requirements
Module: nixie_scan_ctrl

---
 rtl/nixie_scan_ctrl.sv | 123 ++++++++++++
 tb/tb_nixie_scan_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/nixie_scan_ctrl.sv
// Multiplexed nixie/7-segment scan controller: blanked digit scan with a
// double-buffered display word. Optional build macro: LEADING_BLANK_EN.
module nixie_scan_ctrl #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 1000,
  parameter int BLANK_CYC = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  wr_valid,
  input  logic [4*DIGITS-1:0]   wr_data,
  output logic                  wr_ready,
  output logic [3:0]            dig_code,
  output logic [DIGITS-1:0]     dig_sel,
  output logic                  frame_done
);

  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IW      = $clog2(DIGITS);

  typedef enum logic {BLANK, ON} state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [4*DIGITS-1:0]   active_q, active_d;
  logic [4*DIGITS-1:0]   pending_q, pending_d;
  logic                  pend_full_q, pend_full_d;
  logic [3:0]            dig_code_q, dig_code_d;
  logic [DIGITS-1:0]     show;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= BLANK;
      idx_q       <= '0;
      cnt_q       <= '0;
      active_q    <= '0;
      pending_q   <= '0;
      pend_full_q <= 1'b0;
      dig_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      active_q    <= active_d;
      pending_q   <= pending_d;
      pend_full_q <= pend_full_d;
      dig_code_q  <= dig_code_d;
    end
  end

  assign frame_done = (state_q == ON) && (idx_q == IW'(DIGITS - 1)) &&
                      (cnt_q == CW'(SCAN_DIV - 1));
  assign wr_ready   = ~pend_full_q;
  assign dig_code   = dig_code_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    active_d    = active_q;
    pending_d   = pending_q;
    pend_full_d = pend_full_q;

    // Accept and transfer are mutually exclusive: one needs pend_full low, the other high.
    if (frame_done && pend_full_q) begin
      active_d    = pending_q;
      pend_full_d = 1'b0;
    end else if (wr_valid && !pend_full_q) begin
      pending_d   = wr_data;
      pend_full_d = 1'b1;
    end

    if (!en) begin
      state_d = BLANK;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        BLANK: begin
          if (cnt_q == CW'(BLANK_CYC - 1)) begin
            state_d = ON;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ON: begin
          if (cnt_q == CW'(SCAN_DIV - 1)) begin
            state_d = BLANK;
            cnt_d   = '0;
            idx_d   = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = BLANK;
      endcase
    end

    // Tracks the next index/word so the code is stable for the whole digit slot.
    dig_code_d = active_d[4*idx_d +: 4];
  end

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_sel
`ifdef LEADING_BLANK_EN
      if (gi == 0) begin : g_first
        assign show[gi] = 1'b1;
      end else begin : g_rest
        assign show[gi] = |active_q[4*DIGITS-1:4*gi];
      end
`else
      assign show[gi] = 1'b1;
`endif
      assign dig_sel[gi] = (state_q == ON) && (idx_q == IW'(gi)) && show[gi];
    end
  endgenerate

endmodule

// File: tb/tb_nixie_scan_ctrl.sv
// Scoreboard bench for nixie_scan_ctrl: a frame-position model predicts every
// cycle's outputs; a monitor process compares them against the DUT.
module tb_nixie_scan_ctrl;

  localparam int D = 4;
  localparam int S = 4;
  localparam int B = 1;
  localparam int SLOT = B + S;
  localparam int F = D * SLOT;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          wr_valid = 1'b0;
  logic [15:0]   wr_data = '0;
  logic          wr_ready;
  logic [3:0]    dig_code;
  logic [D-1:0]  dig_sel;
  logic          frame_done;

  nixie_scan_ctrl #(.DIGITS(D), .SCAN_DIV(S), .BLANK_CYC(B)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .dig_code(dig_code), .dig_sel(dig_sel),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [D-1:0] sel;
    logic [3:0]   code;
    logic         fd;
    logic         rdy;
    int           t;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Abstract model: display word, pending buffer, and position within the frame.
  logic [15:0] m_active = '0;
  logic [15:0] m_pend = '0;
  bit          m_pf = 0;
  int          m_t = 0;

  function automatic exp_t predict();
    exp_t e;
    int p, d, ph;
    p  = m_t % F;
    d  = p / SLOT;
    ph = p % SLOT;
    e.sel  = (ph < B) ? '0 : D'(1 << d);
`ifdef LEADING_BLANK_EN
    if (d > 0 && (m_active >> (4 * d)) == 16'h0) e.sel = '0;
`endif
    e.code = 4'(m_active >> (4 * d));
    e.fd   = (p == F - 1);
    e.rdy  = !m_pf;
    e.t    = m_t;
    return e;
  endfunction

  task automatic cycle(input bit e, input bit v, input logic [15:0] dat);
    @(negedge clk);
    q.push_back(predict());
    en       = e;
    wr_valid = v;
    wr_data  = dat;
    if (v) $display("write data=%h en=%0d accepted=%0d pos=%0d", dat, e, !m_pf, m_t % F);
    if ((m_t % F == F - 1) && m_pf) begin
      m_active = m_pend;
      m_pf     = 0;
    end else if (v && !m_pf) begin
      m_pend = dat;
      m_pf   = 1;
    end
    m_t = e ? (m_t + 1) % F : 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    en = 1'b0;
    wr_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if (dig_sel !== '0 || wr_ready !== 1'b1 || frame_done !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset: sel=%b rdy=%b fd=%b required sel=0 rdy=1 fd=0",
               dig_sel, wr_ready, frame_done);
    end
    @(negedge clk);
    #3 rst_n = 1'b1;
    m_active = '0;
    m_pend   = '0;
    m_pf     = 0;
    m_t      = 0;
    $display("reset pulse done");
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, '0);
  endtask

  task automatic run_to(input int pos, input bit need_empty);
    for (int i = 0; i < 4 * F; i++) begin
      if (m_t % F == pos && (!need_empty || !m_pf)) break;
      cycle(1, 0, '0);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_checks++;
        if (dig_sel !== e.sel || dig_code !== e.code ||
            frame_done !== e.fd || wr_ready !== e.rdy) begin
          n_errors++;
          $display("FAIL scan_pos%0d: sel=%b code=%h fd=%b rdy=%b required sel=%b code=%h fd=%b rdy=%b",
                   e.t, dig_sel, dig_code, frame_done, wr_ready, e.sel, e.code, e.fd, e.rdy);
        end
      end
    end
  end

  initial begin : stim
    bit          re, rv;
    logic [15:0] rd;
    #23 rst_n = 1'b1;
    // Blank word over one full frame.
    run(F);
    // Mid-frame write, then a refused second write while pending is full.
    run_to(8, 0);
    cycle(1, 1, 16'h7321);
    cycle(1, 1, 16'h9999);
    run(2 * F);
    // Write issued exactly in the frame_done cycle.
    run_to(F - 1, 1);
    cycle(1, 1, 16'h0005);
    run(2 * F + 3);
    // Enable drop during digit 2, with a write while disabled.
    run_to(2 * SLOT + 2, 0);
    cycle(0, 0, '0);
    cycle(0, 1, 16'hC08A);
    cycle(0, 0, '0);
    run(2 * F + 5);
    // Randomized traffic, including codes 8..15 and enable glitches.
    for (int i = 0; i < 400; i++) begin
      re = ($urandom_range(0, 19) != 0);
      rv = ($urandom_range(0, 5) == 0);
      rd = 16'($urandom);
      cycle(re, rv, rd);
    end
    // Reset in the middle of an ON slot while a word is pending.
    run_to(3, 1);
    cycle(1, 1, 16'hABCD);
    run_to(SLOT + 2, 0);
    do_reset();
    run(2 * F);
    @(negedge clk);
    #2;
    if (q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
